// File: rtl/md_pkg.sv
// Shared op encodings, FSM states and default latencies
// for the multiply/divide scheduler.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  function automatic logic is_arith(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) ||
           (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational 64-bit multiply/divide result generator.
// res = {hi, lo}; div_zero flags a divide by zero.
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

  logic               bz;
  logic               ovf;
  logic [31:0]        bd;
  logic [31:0]        bs;
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic signed [31:0] sq;
  logic signed [31:0] sr;
  logic [31:0]        uq;
  logic [31:0]        ur;

  assign bz  = (b == 32'd0);
  assign ovf = (a == 32'h8000_0000) &&
               (b == 32'hffff_ffff);

  // Divisors are steered away from zero and the
  // overflow pair so the dividers never see them.
  assign bd = bz ? 32'd1 : b;
  assign bs = ovf ? 32'd1 : bd;

  assign sprod = $signed({{32{a[31]}}, a}) *
                 $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  assign sq = $signed(a) / $signed(bs);
  assign sr = $signed(a) % $signed(bs);
  assign uq = a / bd;
  assign ur = a % bd;

  always_comb begin
    res = '0;
    unique case (1'b1)
      (op == MD_MULT):  res = sprod;
      (op == MD_MULTU): res = uprod;
      (op == MD_DIV):
        res = ovf ? {32'd0, 32'h8000_0000}
                  : {sr, sq};
      (op == MD_DIVU):  res = {ur, uq};
      default:          res = '0;
    endcase
  end

  assign div_zero = is_div(op) && bz;

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler owning HI/LO;
// raises stall while an op is in flight.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_LAT,
  parameter int DIV_CYCLES  = MD_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_md_use,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAXL = (MULT_CYCLES > DIV_CYCLES)
                      ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] res;
  logic        dz;

  md_alu u_alu (
    .op       (op),
    .a        (a),
    .b        (b),
    .res      (res),
    .div_zero (dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start && is_arith(op)) begin
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          pend_dz_d = dz;
          cnt_d     = is_div(op) ? DIV_LD : MULT_LD;
          state_d   = S_RUN;
        end else if (start && op == MD_MTHI) begin
          hi_d = a;
        end else if (start && op == MD_MTLO) begin
          lo_d = a;
        end
      end
      (state_q == S_RUN): begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          // Divide by zero leaves HI/LO untouched.
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == S_RUN);
  assign stall = d_md_use &
                 (busy | (start & is_arith(op)));

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: expected HI/LO
// and busy lengths queued at issue, checked at commit.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_md_use;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .d_md_use (d_md_use),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n, output bit to);
    n  = 0;
    to = 1'b0;
    while (busy) begin
      n++;
      if (n > 40) begin
        to = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    total++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
    end
    d_md_use = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b want 0", stall);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v[7];
    exp_t e;
    int n;
    bit to;
    logic [31:0] ph;
    v[0] = {MD_MULT,  32'hffff_fffe, 32'd3,
            32'hffff_ffff, 32'hffff_fffa};
    v[1] = {MD_MULTU, 32'hffff_ffff, 32'd2,
            32'd1, 32'hffff_fffe};
    v[2] = {MD_MULT,  32'h8000_0000, 32'h8000_0000,
            32'h4000_0000, 32'd0};
    v[3] = {MD_DIV,   32'hffff_fff9, 32'd2,
            32'hffff_ffff, 32'hffff_fffd};
    v[4] = {MD_DIVU,  32'd100, 32'd7,
            32'd2, 32'd14};
    v[5] = {MD_DIV,   32'h8000_0000, 32'hffff_ffff,
            32'd0, 32'h8000_0000};
    v[6] = {MD_DIV,   32'd7, 32'hffff_fffe,
            32'd1, 32'hffff_fffd};
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{v[i].hi, v[i].lo,
                     (v[i].op >= MD_DIV) ? 10 : 5});
      ph = hi;
      drive(v[i].op, v[i].a, v[i].b);
      total++;
      if (hi !== ph) begin
        bad++;
        $display("FAIL early_hi[%0d]: got %h want %h",
                 i, hi, ph);
      end
      wait_idle(n, to);
      e = sb.pop_front();
      total++;
      if (to || n != e.cyc) begin
        bad++;
        $display("FAIL busy_len[%0d]: got %0d want %0d",
                 i, n, e.cyc);
      end
      total++;
      if (hi !== e.hi || lo !== e.lo) begin
        bad++;
        $display("FAIL result[%0d]: got %h/%h want %h/%h",
                 i, hi, lo, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_div_zero();
    exp_t e;
    int n;
    bit to;
    drive(MD_MTHI, 32'h11, 32'd0);
    drive(MD_MTLO, 32'h22, 32'd0);
    total++;
    if (hi !== 32'h11 || lo !== 32'h22 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mt_write: got %h/%h busy=%b want 11/22 busy=0",
               hi, lo, busy);
    end
    sb.push_back('{32'h11, 32'h22, 10});
    drive(MD_DIVU, 32'd7, 32'd0);
    wait_idle(n, to);
    e = sb.pop_front();
    total++;
    if (to || n != e.cyc) begin
      bad++;
      $display("FAIL dz_len: got %0d want %0d", n, e.cyc);
    end
    total++;
    if (hi !== e.hi || lo !== e.lo) begin
      bad++;
      $display("FAIL dz_keep: got %h/%h want %h/%h",
               hi, lo, e.hi, e.lo);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n;
    bit to;
    sb.push_back('{32'd0, 32'd30, 5});
    drive(MD_MULT, 32'd5, 32'd6);
    wait_idle(n, to);
    e = sb.pop_front();
    total++;
    if (to || hi !== e.hi || lo !== e.lo) begin
      bad++;
      $display("FAIL b2b_first: got %h/%h want %h/%h",
               hi, lo, e.hi, e.lo);
    end
    sb.push_back('{32'd0, 32'd56, 5});
    drive(MD_MULTU, 32'd7, 32'd8);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b want 1", busy);
    end
    wait_idle(n, to);
    e = sb.pop_front();
    total++;
    if (to || n != e.cyc || hi !== e.hi || lo !== e.lo) begin
      bad++;
      $display("FAIL b2b_second: got %h/%h n=%0d want %h/%h n=%0d",
               hi, lo, n, e.hi, e.lo, e.cyc);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    int n;
    d_md_use = 1'b1;
    start = 1'b1;
    op    = MD_MULT;
    a     = 32'd3;
    b     = 32'd4;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL stall_start: got %b want 1", stall);
    end
    sb.push_back('{32'd0, 32'd12, 5});
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n <= 40) begin
      n++;
      total++;
      if (stall !== 1'b1) begin
        bad++;
        $display("FAIL stall_busy[%0d]: got %b want 1", n, stall);
      end
      if (n == 2) begin
        start = 1'b1;
        op    = MD_DIV;
        a     = 32'd100;
        b     = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    #1;
    e = sb.pop_front();
    total++;
    if (n != e.cyc) begin
      bad++;
      $display("FAIL stall_len: got %0d want %0d", n, e.cyc);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_drop: got %b want 0", stall);
    end
    total++;
    if (hi !== e.hi || lo !== e.lo) begin
      bad++;
      $display("FAIL stall_res: got %h/%h want %h/%h",
               hi, lo, e.hi, e.lo);
    end
    start = 1'b1;
    op    = MD_MTHI;
    a     = 32'h0000_abcd;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_mthi: got %b want 0", stall);
    end
    tick();
    start = 1'b0;
    total++;
    if (hi !== 32'h0000_abcd || busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi_after: got %h busy=%b want 0000abcd busy=0",
               hi, busy);
    end
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (busy !== 1'b0 || lo !== 32'd12) begin
      bad++;
      $display("FAIL ignored_start: got busy=%b lo=%h want 0/0000000c",
               busy, lo);
    end
    d_md_use = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive(MD_DIV, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: got busy=%b %h/%h want 0 0/0",
               busy, hi, lo);
    end
    for (int i = 0; i < 12; i++) tick();
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL mid_nocommit: got busy=%b %h/%h want 0 0/0",
               busy, hi, lo);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'd0;
    a        = 32'd0;
    b        = 32'd0;
    d_md_use = 1'b0;
    test_reset();
    test_arith();
    test_div_zero();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
